// File: rtl/trace_packer.sv
// trace_packer: packs pairs of 64-bit trace events {insn, pc} into 128-bit words, queues them, and drains the queue into a DMA FIFO.
// Latency: from the event that completes a word to dma_we is 2 cycles when the queue is empty and dma_writable=1.
// Backpressure: dma_writable gates pops. With a full queue, a completing event is dropped and counted; a flush word is parked in FLUSH_WAIT.
// Ports: cpu_clk/fifo_reset (sync, active-high); trace_en/trace_valid/trace_pc/trace_insn give the event input;
//        flush pushes a partial word; dma_in/dma_we/dma_writable form the downstream write port;
//        q_level, drop_count and busy are status outputs.
module trace_packer #(
  parameter int          QDEPTH = 4,
  parameter logic [63:0] FILL   = 64'hFFFFFFFF_FFFFFFFF
) (
  input  logic         cpu_clk,
  input  logic         fifo_reset,
  input  logic         trace_en,
  input  logic         trace_valid,
  input  logic [31:0]  trace_pc,
  input  logic [31:0]  trace_insn,
  input  logic         flush,
  output logic [127:0] dma_in,
  output logic         dma_we,
  input  logic         dma_writable,
  output logic [4:0]   q_level,
  output logic [15:0]  drop_count,
  output logic         busy
);

  localparam int PW = $clog2(QDEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY      = 2'd0,
    ST_HALF       = 2'd1,
    ST_FLUSH_WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [63:0]     half_q, half_d;
  logic [127:0]    pad_q, pad_d;
  logic [127:0]    mem_q [QDEPTH];
  logic [127:0]    mem_d [QDEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]      level_q, level_d;
  logic [15:0]     drop_q, drop_d;
  logic            dma_we_q, dma_we_d;
  logic [127:0]    dma_in_q, dma_in_d;

  logic            ev;
  logic [63:0]     ev_word;
  logic            pop;
  logic            room;
  logic            push;
  logic [127:0]    push_word;
  logic            drop;
  logic [127:0]    flush_word;

  always_comb begin
    ev         = trace_valid & trace_en;
    ev_word    = {trace_insn, trace_pc};
    pop        = (level_q != 5'd0) & dma_writable;
    // A same-cycle pop frees a slot, so a full queue can still take a push.
    room       = (level_q < 5'(QDEPTH)) | pop;

    state_d    = state_q;
    half_d     = half_q;
    pad_d      = pad_q;
    push       = 1'b0;
    push_word  = '1;
    drop       = 1'b0;
    flush_word = '1;

    case (state_q)
      ST_EMPTY: begin
        if (flush) begin
          if (ev) begin
            flush_word = {FILL, ev_word};
            if (room) begin
              push      = 1'b1;
              push_word = flush_word;
            end else begin
              pad_d   = flush_word;
              state_d = ST_FLUSH_WAIT;
            end
          end
        end else if (ev) begin
          half_d  = ev_word;
          state_d = ST_HALF;
        end
      end
      ST_HALF: begin
        if (flush) begin
          flush_word = ev ? {ev_word, half_q} : {FILL, half_q};
          if (room) begin
            push      = 1'b1;
            push_word = flush_word;
            state_d   = ST_EMPTY;
          end else begin
            pad_d   = flush_word;
            state_d = ST_FLUSH_WAIT;
          end
        end else if (ev) begin
          if (room) begin
            push      = 1'b1;
            push_word = {ev_word, half_q};
            state_d   = ST_EMPTY;
          end else begin
            // Keep the held first half; only the new event is lost.
            drop = 1'b1;
          end
        end
      end
      ST_FLUSH_WAIT: begin
        // Flush pulses are ignored here; events are lost while the padded word waits.
        drop = ev;
        if (room) begin
          push      = 1'b1;
          push_word = pad_q;
          state_d   = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_word;

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    level_d = level_q;
    if (push && !pop)      level_d = level_q + 5'd1;
    else if (!push && pop) level_d = level_q - 5'd1;

    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

    dma_we_d = pop;
    dma_in_d = pop ? mem_q[rd_ptr_q] : '1;
  end

  always_ff @(posedge cpu_clk) begin
    if (fifo_reset) begin
      state_q  <= ST_EMPTY;
      half_q   <= '0;
      pad_q    <= '1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      dma_we_q <= 1'b0;
      dma_in_q <= '1;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      pad_q    <= pad_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      dma_we_q <= dma_we_d;
      dma_in_q <= dma_in_d;
    end
  end

  // Storage needs no reset: entries are only read below level_q.
  always_ff @(posedge cpu_clk) begin
    mem_q <= mem_d;
  end

  assign dma_in     = dma_in_q;
  assign dma_we     = dma_we_q;
  assign q_level    = level_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != ST_EMPTY) | (level_q != 5'd0) | dma_we_q;

endmodule

// File: tb/tb_trace_packer.sv
module tb_trace_packer;

  localparam int          QD   = 4;
  localparam logic [63:0] FILL = 64'hFFFFFFFF_FFFFFFFF;

  logic         cpu_clk;
  logic         fifo_reset;
  logic         trace_en;
  logic         trace_valid;
  logic [31:0]  trace_pc;
  logic [31:0]  trace_insn;
  logic         flush;
  logic [127:0] dma_in;
  logic         dma_we;
  logic         dma_writable;
  logic [4:0]   q_level;
  logic [15:0]  drop_count;
  logic         busy;

  int total = 0;
  int bad   = 0;

  trace_packer #(.QDEPTH(QD), .FILL(FILL)) dut (
    .cpu_clk      (cpu_clk),
    .fifo_reset   (fifo_reset),
    .trace_en     (trace_en),
    .trace_valid  (trace_valid),
    .trace_pc     (trace_pc),
    .trace_insn   (trace_insn),
    .flush        (flush),
    .dma_in       (dma_in),
    .dma_we       (dma_we),
    .dma_writable (dma_writable),
    .q_level      (q_level),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  // Behavioural reference: a queue of words, an optional held half and an optional parked flush word.
  logic [127:0] mq[$];
  logic         m_hold;
  logic [63:0]  m_half;
  logic         m_wait;
  logic [127:0] m_pad;
  logic [15:0]  m_drop;
  logic         m_we;
  logic [127:0] m_din;

  task automatic model_drop();
    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
  endtask

  task automatic model_step(input logic rst, input logic v, input logic en,
                            input logic [31:0] pc, input logic [31:0] insn,
                            input logic fl, input logic wr);
    logic         e;
    logic [63:0]  evw;
    logic [127:0] w;
    logic         room;
    if (rst) begin
      mq.delete();
      m_hold = 0; m_wait = 0; m_drop = 0; m_we = 0; m_din = '1; m_half = '0; m_pad = '1;
      return;
    end
    if (mq.size() != 0 && wr) begin
      m_we  = 1;
      m_din = mq.pop_front();
    end else begin
      m_we  = 0;
      m_din = '1;
    end
    room = (mq.size() < QD);
    e    = v && en;
    evw  = {insn, pc};
    if (m_wait) begin
      if (e) model_drop();
      if (room) begin
        mq.push_back(m_pad);
        m_wait = 0;
      end
    end else if (fl) begin
      if (m_hold || e) begin
        if (m_hold) w = e ? {evw, m_half} : {FILL, m_half};
        else        w = {FILL, evw};
        m_hold = 0;
        if (room) mq.push_back(w);
        else begin m_wait = 1; m_pad = w; end
      end
    end else if (e) begin
      if (!m_hold) begin
        m_hold = 1; m_half = evw;
      end else if (room) begin
        mq.push_back({evw, m_half});
        m_hold = 0;
      end else begin
        model_drop();
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and return at the following negedge.
  task automatic step(input logic rst, input logic v, input logic en,
                      input logic [31:0] pc, input logic [31:0] insn,
                      input logic fl, input logic wr);
    fifo_reset   = rst;
    trace_valid  = v;
    trace_en     = en;
    trace_pc     = pc;
    trace_insn   = insn;
    flush        = fl;
    dma_writable = wr;
    model_step(rst, v, en, pc, insn, fl, wr);
    @(posedge cpu_clk);
    @(negedge cpu_clk);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    total++; if (q_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", q_level); end
    total++; if (dma_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", dma_we); end
    total++; if (dma_in !== {128{1'b1}}) begin bad++; $display("FAIL reset_din got=%h exp=all-ones", dma_in); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if (dma_we !== 1'b0) begin bad++; $display("FAIL post_reset_we got=%b exp=0", dma_we); end
  endtask

  task automatic test_pair();
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 32'h100, 32'h13, 0, 1);
    step(0, 1, 1, 32'h104, 32'h93, 0, 1);
    total++; if (dma_we !== 1'b0 || q_level !== 5'd1) begin bad++; $display("FAIL pair_lat1 we=%b lvl=%0d exp we=0 lvl=1", dma_we, q_level); end
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if (dma_we !== 1'b1) begin bad++; $display("FAIL pair_we got=%b exp=1", dma_we); end
    total++; if (dma_in !== 128'h00000093_00000104_00000013_00000100) begin bad++; $display("FAIL pair_din got=%h exp=00000093000001040000001300000100", dma_in); end
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if (dma_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL pair_after we=%b busy=%b exp 0 0", dma_we, busy); end
  endtask

  task automatic test_flush_half();
    int we_seen;
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 32'h200, 32'h6F, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if (dma_we !== 1'b1 || dma_in !== 128'hFFFFFFFF_FFFFFFFF_0000006F_00000200) begin
      bad++; $display("FAIL flush_half we=%b din=%h exp we=1 din=ffffffffffffffff0000006f00000200", dma_we, dma_in);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    we_seen = 0;
    step(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      if (dma_we === 1'b1) we_seen++;
    end
    total++; if (we_seen != 0 || busy !== 1'b0) begin bad++; $display("FAIL flush_empty we_count=%0d busy=%b exp 0 0", we_seen, busy); end
  endtask

  task automatic test_overflow();
    logic [31:0] pc[13];
    logic [31:0] in[13];
    logic [127:0] exp;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin pc[i] = $urandom; in[i] = $urandom; end
    for (int i = 0; i < 12; i++) step(0, 1, 1, pc[i], in[i], 0, 0);
    total++; if (q_level !== 5'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", q_level); end
    total++; if (drop_count !== 16'd3) begin bad++; $display("FAIL ovf_drop got=%0d exp=3", drop_count); end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      exp = {in[2*k+1], pc[2*k+1], in[2*k], pc[2*k]};
      total++; if (dma_we !== 1'b1 || dma_in !== exp) begin bad++; $display("FAIL ovf_word%0d we=%b din=%h exp=%h", k, dma_we, dma_in, exp); end
    end
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if (dma_we !== 1'b0 || q_level !== 5'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL ovf_half_held we=%b lvl=%0d busy=%b exp 0 0 1", dma_we, q_level, busy);
    end
    step(0, 1, 1, pc[12], in[12], 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    exp = {in[12], pc[12], in[8], pc[8]};
    total++; if (dma_we !== 1'b1 || dma_in !== exp) begin bad++; $display("FAIL ovf_kept_half we=%b din=%h exp=%h", dma_we, dma_in, exp); end
  endtask

  task automatic test_flush_wait();
    logic [31:0] pc[11];
    logic [31:0] in[11];
    logic [127:0] exp[5];
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin pc[i] = $urandom; in[i] = $urandom; end
    for (int k = 0; k < 4; k++) exp[k] = {in[2*k+1], pc[2*k+1], in[2*k], pc[2*k]};
    exp[4] = {FILL, in[8], pc[8]};
    for (int i = 0; i < 9; i++) step(0, 1, 1, pc[i], in[i], 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, pc[9], in[9], 1, 0);
    step(0, 1, 1, pc[10], in[10], 0, 0);
    total++; if (drop_count !== 16'd2 || q_level !== 5'd4 || busy !== 1'b1) begin
      bad++; $display("FAIL fw_hold drop=%0d lvl=%0d busy=%b exp 2 4 1", drop_count, q_level, busy);
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      total++; if (dma_we !== 1'b1 || dma_in !== exp[k] || busy !== 1'b1) begin
        bad++; $display("FAIL fw_word%0d we=%b busy=%b din=%h exp=%h", k, dma_we, busy, dma_in, exp[k]);
      end
      if (k == 0) begin
        total++; if (q_level !== 5'd4) begin bad++; $display("FAIL fw_pad_queued lvl=%0d exp=4", q_level); end
      end
    end
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if (dma_we !== 1'b0 || busy !== 1'b0 || drop_count !== 16'd2) begin
      bad++; $display("FAIL fw_done we=%b busy=%b drop=%0d exp 0 0 2", dma_we, busy, drop_count);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, $urandom, $urandom, 0, 0);
    total++; if (q_level !== 5'd3) begin bad++; $display("FAIL rm_level got=%0d exp=3", q_level); end
    step(1, 1, 1, $urandom, $urandom, 0, 1);
    total++; if (q_level !== 5'd0 || dma_we !== 1'b0 || dma_in !== {128{1'b1}} || drop_count !== 16'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL rm_cleared lvl=%0d we=%b din=%h drop=%0d busy=%b exp 0 0 all-ones 0 0", q_level, dma_we, dma_in, drop_count, busy);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, $urandom, $urandom, 0, 1);
      total++; if (dma_we !== 1'b0 || q_level !== 5'd0 || busy !== 1'b0) begin
        bad++; $display("FAIL rm_disabled%0d we=%b lvl=%0d busy=%b exp 0 0 0", i, dma_we, q_level, busy);
      end
    end
  endtask

  task automatic test_random();
    logic exp_busy;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 85,
           $urandom, $urandom, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 45);
      exp_busy = m_hold || m_wait || (mq.size() != 0) || m_we;
      total++;
      if (dma_we !== m_we || dma_in !== m_din || q_level !== 5'(mq.size()) || drop_count !== m_drop || busy !== exp_busy) begin
        bad++;
        $display("FAIL rand_cyc%0d we=%b/%b lvl=%0d/%0d drop=%0d/%0d busy=%b/%b din=%h/%h (got/exp)",
                 c, dma_we, m_we, q_level, mq.size(), drop_count, m_drop, busy, exp_busy, dma_in, m_din);
      end
    end
  endtask

  initial begin
    fifo_reset = 1; trace_en = 0; trace_valid = 0; trace_pc = 0; trace_insn = 0;
    flush = 0; dma_writable = 0;
    @(negedge cpu_clk);
    test_reset();
    test_pair();
    test_flush_half();
    test_overflow();
    test_flush_wait();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
